// File: rtl/uart_frame_rx.sv
// UART frame receiver: sliding magic-header hunt, fixed-length payload, trailing CRC-16 check.
// Publishes the payload only on a good CRC; CRC and inter-byte timeout errors are counted.
module uart_frame_rx #(
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter int unsigned MAGIC_BYTES    = 4,
  parameter logic [31:0] MAGIC          = 32'hDABBAD00,
  parameter logic [15:0] CRC_POLY       = 16'h1021,
  parameter logic [15:0] CRC_INIT       = 16'hFFFF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       frame_valid,
  output logic                       crc_error,
  output logic                       timeout_error,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic [15:0]                error_count
);

  localparam int unsigned PW = PAYLOAD_BYTES * 8;
  localparam int unsigned HW = MAGIC_BYTES * 8;
  localparam int unsigned IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hdr_q, hdr_d;
  logic [HW+7:0]   hdr_ext;
  logic [15:0]     crc_q, crc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [7:0]      crc_hi_q, crc_hi_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            frame_valid_q, frame_valid_d;
  logic            crc_error_q, crc_error_d;
  logic            timeout_error_q, timeout_error_d;
  logic            busy_q, busy_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [15:0]     error_count_q, error_count_d;
  logic            expired;

  // One byte of MSB-first CRC, no reflection.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d         = state_q;
    hdr_d           = hdr_q;
    crc_d           = crc_q;
    idx_d           = idx_q;
    tmo_d           = tmo_q;
    crc_hi_d        = crc_hi_q;
    buf_d           = buf_q;
    payload_d       = payload_q;
    frame_valid_d   = 1'b0;
    crc_error_d     = 1'b0;
    timeout_error_d = 1'b0;
    frame_count_d   = frame_count_q;
    error_count_d   = error_count_q;
    hdr_ext         = {hdr_q, rx_byte};
    expired         = (state_q != HUNT) && !rx_valid && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

    if (state_q != HUNT) tmo_d = rx_valid ? 16'h0000 : tmo_q + 16'h0001;

    case (state_q)
      HUNT: if (rx_valid) begin
        hdr_d = hdr_ext[HW-1:0];
        if (hdr_ext[HW-1:0] == MAGIC[HW-1:0]) begin
          state_d = PAYLOAD;
          crc_d   = CRC_INIT;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      PAYLOAD: if (rx_valid) begin
        buf_d[{idx_q, 3'b000} +: 8] = rx_byte;
        crc_d = crc_step(crc_q, rx_byte);
        if (idx_q == IW'(PAYLOAD_BYTES - 1)) state_d = CRC_HI;
        else                                 idx_d   = idx_q + 1'b1;
      end
      CRC_HI: if (rx_valid) begin
        crc_hi_d = rx_byte;
        state_d  = CRC_LO;
      end
      CRC_LO: if (rx_valid) begin
        if ({crc_hi_q, rx_byte} == crc_q) begin
          payload_d     = buf_q;
          frame_valid_d = 1'b1;
          if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'h0001;
        end else begin
          crc_error_d = 1'b1;
          if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'h0001;
        end
        hdr_d   = '0;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    // Expiry only fires when no byte arrives, so it never collides with the CRC_LO pulses.
    if (expired) begin
      timeout_error_d = 1'b1;
      if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'h0001;
      hdr_d   = '0;
      tmo_d   = '0;
      state_d = HUNT;
    end

    busy_d = (state_d != HUNT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q         <= HUNT;
      hdr_q           <= '0;
      crc_q           <= CRC_INIT;
      idx_q           <= '0;
      tmo_q           <= '0;
      crc_hi_q        <= '0;
      payload_q       <= '0;
      frame_valid_q   <= 1'b0;
      crc_error_q     <= 1'b0;
      timeout_error_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_count_q   <= '0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      hdr_q           <= hdr_d;
      crc_q           <= crc_d;
      idx_q           <= idx_d;
      tmo_q           <= tmo_d;
      crc_hi_q        <= crc_hi_d;
      payload_q       <= payload_d;
      frame_valid_q   <= frame_valid_d;
      crc_error_q     <= crc_error_d;
      timeout_error_q <= timeout_error_d;
      busy_q          <= busy_d;
      frame_count_q   <= frame_count_d;
      error_count_q   <= error_count_d;
    end
  end

  // NOTE: the working buffer has no reset; every slot is rewritten before it can reach payload.
  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

  assign payload       = payload_q;
  assign frame_valid   = frame_valid_q;
  assign crc_error     = crc_error_q;
  assign timeout_error = timeout_error_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: default instance plus a 9-byte-payload instance.
// CRC-CCITT-FALSE of 01 02 03 04 is 16'h89C3; of "123456789" is 16'h29B1.
module tb_uart_frame_rx;

  logic        CLK;
  logic        RST_N;
  logic        rx_valid, rx_valid9;
  logic [7:0]  rx_byte, rx_byte9;
  logic [31:0] payload;
  logic [71:0] payload9;
  logic        frame_valid, crc_error, timeout_error, busy;
  logic        frame_valid9, crc_error9, timeout_error9, busy9;
  logic [15:0] frame_count, error_count, frame_count9, error_count9;

  int n_checks = 0;
  int n_pass   = 0;

  uart_frame_rx dut (
    .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .payload(payload), .frame_valid(frame_valid), .crc_error(crc_error),
    .timeout_error(timeout_error), .busy(busy),
    .frame_count(frame_count), .error_count(error_count)
  );

  uart_frame_rx #(.PAYLOAD_BYTES(9)) dut9 (
    .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid9), .rx_byte(rx_byte9),
    .payload(payload9), .frame_valid(frame_valid9), .crc_error(crc_error9),
    .timeout_error(timeout_error9), .busy(busy9),
    .frame_count(frame_count9), .error_count(error_count9)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        busy;
    logic        fv;
    logic        ce;
    logic        te;
    logic [15:0] fc;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge CLK);
    rx_valid = v;
    rx_byte  = b;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic cyc9(input logic v, input logic [7:0] b);
    @(negedge CLK);
    rx_valid9 = v;
    rx_byte9  = b;
    @(posedge CLK);
    #1;
    rx_valid9 = 1'b0;
  endtask

  task automatic send_hdr();
    cyc(1, 8'hDA); cyc(1, 8'hBB); cyc(1, 8'hAD); cyc(1, 8'h00);
  endtask

  task automatic send_body();
    cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03); cyc(1, 8'h04);
  endtask

  task automatic send_digits9(input logic [7:0] crc_lo);
    string s;
    s = "123456789";
    cyc9(1, 8'hDA); cyc9(1, 8'hBB); cyc9(1, 8'hAD); cyc9(1, 8'h00);
    for (int i = 0; i < 9; i++) cyc9(1, s[i]);
    cyc9(1, 8'h29);
    cyc9(1, crc_lo);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    RST_N = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rx_valid9 = 1'b0; rx_byte9 = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_payload", 72'(payload), 72'h0);
    check("rst_flags", 72'({busy, frame_valid, crc_error, timeout_error}), 72'h0);
    check("rst_counts", 72'({frame_count, error_count}), 72'h0);
    @(negedge CLK) RST_N = 1'b1;

    // Good frame with gaps, then a back-to-back second frame.
    tbl = '{
      '{1'b1, 8'hDA, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'h89, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'hDA, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'h89, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1},
      '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2}
    };
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].v, tbl[i].b);
      check($sformatf("vec%0d", i),
            72'({busy, frame_valid, crc_error, timeout_error, frame_count}),
            72'({tbl[i].busy, tbl[i].fv, tbl[i].ce, tbl[i].te, tbl[i].fc}));
    end
    check("good_payload", 72'(payload), 72'h04030201);
    check("good_errcnt", 72'(error_count), 72'h0);

    // Sliding header recovery.
    cyc(1, 8'h55); cyc(1, 8'hDA); cyc(1, 8'hDA); cyc(1, 8'hBB); cyc(1, 8'hAD);
    check("slide_busy_pre", 72'(busy), 72'h0);
    cyc(1, 8'h00);
    check("slide_busy_post", 72'(busy), 72'h1);
    send_body(); cyc(1, 8'h89); cyc(1, 8'hC3);
    check("slide_fv", 72'({frame_valid, frame_count}), 72'({1'b1, 16'd3}));

    // Timeout at exactly TIMEOUT_CYCLES idle clocks.
    send_hdr(); cyc(1, 8'h01); cyc(1, 8'h02);
    seen = 1'b0;
    repeat (4095) begin
      cyc(0, 8'h00);
      if (timeout_error || !busy) seen = 1'b1;
    end
    check("tmo_early", 72'(seen), 72'h0);
    cyc(0, 8'h00);
    check("tmo_fire", 72'({timeout_error, busy, error_count}), 72'({1'b1, 1'b0, 16'd1}));
    cyc(0, 8'h00);
    check("tmo_pulse_end", 72'(timeout_error), 72'h0);

    // Byte in the expiry cycle: no timeout, frame continues.
    send_hdr(); cyc(1, 8'h01); cyc(1, 8'h02);
    seen = 1'b0;
    repeat (4095) begin
      cyc(0, 8'h00);
      if (timeout_error || !busy) seen = 1'b1;
    end
    check("tmo_var_early", 72'(seen), 72'h0);
    cyc(1, 8'h03);
    check("tmo_var_none", 72'({timeout_error, busy}), 72'({1'b0, 1'b1}));
    cyc(1, 8'h04); cyc(1, 8'h89); cyc(1, 8'hC3);
    check("tmo_var_fv", 72'({frame_valid, frame_count, error_count}),
          72'({1'b1, 16'd4, 16'd1}));

    // Reset mid-payload.
    send_hdr(); cyc(1, 8'h01); cyc(1, 8'h02);
    @(negedge CLK) RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_flags", 72'({busy, frame_valid, crc_error, timeout_error}), 72'h0);
    check("mid_rst_counts", 72'({frame_count, error_count, payload}), 72'h0);
    @(negedge CLK) RST_N = 1'b1;
    cyc(0, 8'h00);
    check("mid_rst_quiet", 72'({busy, frame_valid, crc_error, timeout_error}), 72'h0);
    send_hdr(); send_body(); cyc(1, 8'h89); cyc(1, 8'hC3);
    check("mid_rst_fv", 72'({frame_valid, frame_count, error_count}), 72'({1'b1, 16'd1, 16'd0}));

    // Error counter saturation.
    @(negedge CLK) force dut.error_count_q = 16'hFFFE;
    @(posedge CLK);
    @(negedge CLK) release dut.error_count_q;
    cyc(0, 8'h00);
    check("sat_preload", 72'(error_count), 72'hFFFE);
    send_hdr(); send_body(); cyc(1, 8'h89); cyc(1, 8'hC4);
    check("sat_bad1", 72'({crc_error, frame_valid, error_count}), 72'({1'b1, 1'b0, 16'hFFFF}));
    send_hdr(); send_body(); cyc(1, 8'h89); cyc(1, 8'hC4);
    check("sat_bad2", 72'({crc_error, error_count}), 72'({1'b1, 16'hFFFF}));
    check("sat_payload", 72'({payload, frame_count}), 72'({32'h04030201, 16'd1}));

    // Nine-byte payload instance: good then bad CRC.
    send_digits9(8'hB1);
    check("p9_fv", 72'({frame_valid9, crc_error9, frame_count9}), 72'({1'b1, 1'b0, 16'd1}));
    check("p9_payload", payload9, 72'h393837363534333231);
    send_digits9(8'hB0);
    check("p9_ce", 72'({crc_error9, frame_valid9, error_count9}), 72'({1'b1, 1'b0, 16'd1}));
    check("p9_payload_hold", payload9, 72'h393837363534333231);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
